// File: rtl/bsc_sequencer_if.sv
// Control bundle between instruction fetch, the bsc_sequencer and the bit-serial datapath.
// The master side issues start/instr; the slave side is the sequencer that drives the strobes.
interface bsc_sequencer_if #(
    parameter int WIDTH = 8,
    parameter int CW    = $clog2(WIDTH)
);
    logic          start;
    logic [15:0]   instr;
    logic          busy;
    logic          done;
    logic          illegal;
    logic [CW-1:0] bit_idx;
    logic [2:0]    rf_addr;
    logic          rf_rd_en;
    logic          rf_wr_en;
    logic          op_a_shift_en;
    logic          op_b_shift_en;
    logic          b_sel_imm;
    logic          imm_bit;
    logic [1:0]    alu_op;
    logic          b_invert;
    logic          carry_init;
    logic          carry_val;
    logic          carry_en;
    logic          acc_shift_en;

    modport master (
        output start, instr,
        input  busy, done, illegal, bit_idx, rf_addr, rf_rd_en, rf_wr_en,
               op_a_shift_en, op_b_shift_en, b_sel_imm, imm_bit, alu_op,
               b_invert, carry_init, carry_val, carry_en, acc_shift_en
    );

    modport slave (
        input  start, instr,
        output busy, done, illegal, bit_idx, rf_addr, rf_rd_en, rf_wr_en,
               op_a_shift_en, op_b_shift_en, b_sel_imm, imm_bit, alu_op,
               b_invert, carry_init, carry_val, carry_en, acc_shift_en
    );
endinterface

// File: rtl/bsc_sequencer.sv
// Control sequencer for the bit-serial CPU: start/busy/done handshake, internal bit counter,
// LSB-first operand loading, ALU execution and optional register write-back.
module bsc_sequencer #(
    parameter int WIDTH = 8,
    parameter int IMM_W = 6,
    parameter int WB_EN = 1,
    parameter int CW    = $clog2(WIDTH)
) (
    input logic           clk,
    input logic           rstn,
    bsc_sequencer_if.slave bus
);

    typedef enum logic [2:0] {
        IDLE,
        LOAD_A,
        LOAD_B,
        EXEC,
        WB,
        DONE
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_nxt;
    logic [15:0]   ir;

    logic [3:0]       opcode;
    logic [2:0]       rd;
    logic [2:0]       rs1;
    logic [2:0]       rs2;
    logic             last;
    logic             do_wb;
    logic [WIDTH-1:0] imm_ext;

    function automatic logic is_legal(input logic [3:0] op);
        case (op[2:0])
            3'b000, 3'b001, 3'b100, 3'b101, 3'b110: is_legal = 1'b1;
            default:                                is_legal = 1'b0;
        endcase
    endfunction

    function automatic logic [1:0] alu_decode(input logic [3:0] op);
        case (op[2:0])
            3'b100:  alu_decode = 2'b11;
            3'b101:  alu_decode = 2'b10;
            3'b110:  alu_decode = 2'b01;
            default: alu_decode = 2'b00;
        endcase
    endfunction

    assign opcode = ir[3:0];
    assign rd     = ir[6:4];
    assign rs1    = ir[9:7];
    assign rs2    = ir[12:10];
    assign last   = (cnt == CW'(WIDTH - 1));
    assign do_wb  = (WB_EN != 0) && (rd != 3'd0);

    // Immediate pre-extended to WIDTH bits so the LSB-first stream is a plain index by cnt
    for (genvar i = 0; i < WIDTH; i++) begin : g_imm
        if (i < IMM_W) begin : g_field
            assign imm_ext[i] = ir[10 + i];
        end else begin : g_sign
            assign imm_ext[i] = ir[10 + IMM_W - 1];
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= IDLE;
            cnt   <= '0;
            ir    <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            if (state == IDLE && bus.start) begin
                ir <= bus.instr;
            end
        end
    end

    always_comb begin
        state_nxt         = state;
        cnt_nxt           = '0;
        bus.busy          = (state != IDLE);
        bus.done          = 1'b0;
        bus.illegal       = 1'b0;
        bus.bit_idx       = cnt;
        bus.rf_addr       = 3'd0;
        bus.rf_rd_en      = 1'b0;
        bus.rf_wr_en      = 1'b0;
        bus.op_a_shift_en = 1'b0;
        bus.op_b_shift_en = 1'b0;
        bus.b_sel_imm     = 1'b0;
        bus.imm_bit       = 1'b0;
        bus.alu_op        = 2'b00;
        bus.b_invert      = 1'b0;
        bus.carry_init    = 1'b0;
        bus.carry_val     = 1'b0;
        bus.carry_en      = 1'b0;
        bus.acc_shift_en  = 1'b0;

        if (state != IDLE && state != DONE) begin
            cnt_nxt = last ? '0 : cnt + CW'(1);
        end

        case (state)
            IDLE: begin
                if (bus.start) begin
                    state_nxt = is_legal(bus.instr[3:0]) ? LOAD_A : DONE;
                end
            end
            LOAD_A: begin
                bus.rf_addr       = rs1;
                bus.rf_rd_en      = 1'b1;
                bus.op_a_shift_en = 1'b1;
                if (last) state_nxt = LOAD_B;
            end
            LOAD_B: begin
                bus.op_b_shift_en = 1'b1;
                if (opcode[3]) begin
                    bus.b_sel_imm = 1'b1;
                    bus.imm_bit   = imm_ext[cnt];
                end else begin
                    bus.rf_addr  = rs2;
                    bus.rf_rd_en = 1'b1;
                end
                if (last) state_nxt = EXEC;
            end
            EXEC: begin
                bus.alu_op       = alu_decode(opcode);
                bus.b_invert     = (opcode[2:0] == 3'b001);
                bus.carry_val    = (opcode[2:0] == 3'b001);
                bus.carry_init   = (cnt == '0);
                bus.carry_en     = 1'b1;
                bus.acc_shift_en = 1'b1;
                if (last) state_nxt = do_wb ? WB : DONE;
            end
            WB: begin
                bus.rf_addr      = rd;
                bus.rf_wr_en     = 1'b1;
                bus.acc_shift_en = 1'b1;
                if (last) state_nxt = DONE;
            end
            DONE: begin
                bus.done    = 1'b1;
                bus.illegal = !is_legal(opcode);
                state_nxt   = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule

// File: tb/tb_bsc_sequencer.sv
// Directed bench for bsc_sequencer: three instances (8-bit, 8-bit without write-back, 16-bit)
// checked cycle by cycle against a time-based model, with a queue of expected completions.
module tb_bsc_sequencer;

    logic clk = 1'b0;
    logic rstn;

    always #5 clk = ~clk;

    bsc_sequencer_if #(.WIDTH(8))  bus_a ();
    bsc_sequencer_if #(.WIDTH(8))  bus_b ();
    bsc_sequencer_if #(.WIDTH(16)) bus_c ();

    bsc_sequencer #(.WIDTH(8),  .IMM_W(6), .WB_EN(1)) dut_a (.clk(clk), .rstn(rstn), .bus(bus_a));
    bsc_sequencer #(.WIDTH(8),  .IMM_W(6), .WB_EN(0)) dut_b (.clk(clk), .rstn(rstn), .bus(bus_b));
    bsc_sequencer #(.WIDTH(16), .IMM_W(6), .WB_EN(1)) dut_c (.clk(clk), .rstn(rstn), .bus(bus_c));

    typedef struct packed {
        logic       busy;
        logic       done;
        logic       illegal;
        logic [7:0] bit_idx;
        logic [2:0] rf_addr;
        logic       rf_rd_en;
        logic       rf_wr_en;
        logic       op_a;
        logic       op_b;
        logic       b_sel_imm;
        logic       imm_bit;
        logic [1:0] alu_op;
        logic       b_invert;
        logic       carry_init;
        logic       carry_val;
        logic       carry_en;
        logic       acc_shift_en;
    } outs_t;

    typedef struct {
        int          dut;
        logic [15:0] instr;
        int          lat;
    } exp_t;

    outs_t obs_a, obs_b, obs_c;
    exp_t  sb[$];
    int    checks   = 0;
    int    failures = 0;

    assign obs_a = {bus_a.busy, bus_a.done, bus_a.illegal, 8'(bus_a.bit_idx), bus_a.rf_addr,
                    bus_a.rf_rd_en, bus_a.rf_wr_en, bus_a.op_a_shift_en, bus_a.op_b_shift_en,
                    bus_a.b_sel_imm, bus_a.imm_bit, bus_a.alu_op, bus_a.b_invert,
                    bus_a.carry_init, bus_a.carry_val, bus_a.carry_en, bus_a.acc_shift_en};
    assign obs_b = {bus_b.busy, bus_b.done, bus_b.illegal, 8'(bus_b.bit_idx), bus_b.rf_addr,
                    bus_b.rf_rd_en, bus_b.rf_wr_en, bus_b.op_a_shift_en, bus_b.op_b_shift_en,
                    bus_b.b_sel_imm, bus_b.imm_bit, bus_b.alu_op, bus_b.b_invert,
                    bus_b.carry_init, bus_b.carry_val, bus_b.carry_en, bus_b.acc_shift_en};
    assign obs_c = {bus_c.busy, bus_c.done, bus_c.illegal, 8'(bus_c.bit_idx), bus_c.rf_addr,
                    bus_c.rf_rd_en, bus_c.rf_wr_en, bus_c.op_a_shift_en, bus_c.op_b_shift_en,
                    bus_c.b_sel_imm, bus_c.imm_bit, bus_c.alu_op, bus_c.b_invert,
                    bus_c.carry_init, bus_c.carry_val, bus_c.carry_en, bus_c.acc_shift_en};

    function automatic int dutWidth(input int d);
        return (d == 2) ? 16 : 8;
    endfunction

    function automatic bit dutWb(input int d);
        return (d != 1);
    endfunction

    function automatic outs_t getObs(input int d);
        return (d == 0) ? obs_a : (d == 1) ? obs_b : obs_c;
    endfunction

    function automatic logic [15:0] mkR(input logic [3:0] op, input logic [2:0] rd,
                                        input logic [2:0] rs1, input logic [2:0] rs2);
        return {3'b000, rs2, rs1, rd, op};
    endfunction

    function automatic logic [15:0] mkI(input logic [3:0] op, input logic [2:0] rd,
                                        input logic [2:0] rs1, input logic [5:0] imm);
        return {imm, rs1, rd, op};
    endfunction

    function automatic bit opLegal(input logic [3:0] opc);
        case (opc)
            4'h0, 4'h1, 4'h4, 4'h5, 4'h6, 4'h8, 4'h9, 4'hC, 4'hD, 4'hE: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    // Cycles from the start-sampling edge to the done cycle
    function automatic int expLat(input logic [15:0] ins, input int w, input bit wb);
        if (!opLegal(ins[3:0])) return 1;
        if (wb && ins[6:4] != 3'd0) return 4 * w + 1;
        return 3 * w + 1;
    endfunction

    // Expected outputs k clock edges after start was sampled, derived from elapsed time
    function automatic outs_t expOut(input logic [15:0] ins, input int k, input int w, input bit wb);
        outs_t      e = '0;
        logic [3:0] opc = ins[3:0];
        logic [5:0] imm = ins[15:10];
        logic [1:0] alu = 2'b00;
        bit         sub = 1'b0;
        int         nph;
        int         p;
        int         b;
        case (opc)
            4'h1, 4'h9: sub = 1'b1;
            4'h4, 4'hC: alu = 2'b11;
            4'h5, 4'hD: alu = 2'b10;
            4'h6, 4'hE: alu = 2'b01;
            default:    alu = 2'b00;
        endcase
        if (!opLegal(opc)) begin
            if (k == 1) begin
                e.busy    = 1'b1;
                e.done    = 1'b1;
                e.illegal = 1'b1;
            end
            return e;
        end
        nph = (wb && ins[6:4] != 3'd0) ? 4 : 3;
        if (k >= 1 && k <= nph * w) begin
            p = (k - 1) / w;
            b = (k - 1) % w;
            e.busy    = 1'b1;
            e.bit_idx = 8'(b);
            case (p)
                0: begin
                    e.rf_addr  = ins[9:7];
                    e.rf_rd_en = 1'b1;
                    e.op_a     = 1'b1;
                end
                1: begin
                    e.op_b = 1'b1;
                    if (opc[3]) begin
                        e.b_sel_imm = 1'b1;
                        e.imm_bit   = (b < 6) ? imm[b] : imm[5];
                    end else begin
                        e.rf_addr  = ins[12:10];
                        e.rf_rd_en = 1'b1;
                    end
                end
                2: begin
                    e.alu_op       = alu;
                    e.b_invert     = sub;
                    e.carry_val    = sub;
                    e.carry_init   = (b == 0);
                    e.carry_en     = 1'b1;
                    e.acc_shift_en = 1'b1;
                end
                default: begin
                    e.rf_addr      = ins[6:4];
                    e.rf_wr_en     = 1'b1;
                    e.acc_shift_en = 1'b1;
                end
            endcase
        end else if (k == nph * w + 1) begin
            e.busy = 1'b1;
            e.done = 1'b1;
        end
        return e;
    endfunction

    task automatic checkVec(input string tag, input outs_t obs, input outs_t exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic checkInt(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic driveIn(input int d, input logic s, input logic [15:0] ins);
        case (d)
            0:       begin bus_a.start = s; bus_a.instr = ins; end
            1:       begin bus_b.start = s; bus_b.instr = ins; end
            default: begin bus_c.start = s; bus_c.instr = ins; end
        endcase
    endtask

    // Confirms the instance is idle, raises start for one edge and queues the expected completion
    task automatic applyStimulus(input int d, input logic [15:0] ins);
        exp_t r;
        @(negedge clk);
        checkVec($sformatf("idle d%0d before %h", d, ins), getObs(d), '0);
        driveIn(d, 1'b1, ins);
        r.dut   = d;
        r.instr = ins;
        r.lat   = expLat(ins, dutWidth(d), dutWb(d));
        sb.push_back(r);
    endtask

    // Follows the oldest queued operation cycle by cycle; optional mid-run start poke,
    // start held through DONE, or an asynchronous reset at cycle abort_k
    task automatic checkOutput(input int poke_k, input logic [15:0] poke_ins,
                               input bit hold, input logic [15:0] hold_ins, input int abort_k);
        exp_t  r;
        outs_t o;
        int    first_done = -1;
        if (sb.size() == 0) begin
            checkInt("scoreboard empty", 0, 1);
            return;
        end
        r = sb.pop_front();
        for (int k = 1; k <= r.lat; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (k == 1) driveIn(r.dut, 1'b0, r.instr);
            if (poke_k > 0 && k == poke_k + 1) driveIn(r.dut, 1'b0, poke_ins);
            o = getObs(r.dut);
            checkVec($sformatf("d%0d op %h k%0d", r.dut, r.instr, k), o,
                     expOut(r.instr, k, dutWidth(r.dut), dutWb(r.dut)));
            checkInt($sformatf("excl d%0d k%0d", r.dut, k),
                     int'(!(o.rf_rd_en && o.rf_wr_en) && $onehot0({o.op_a, o.op_b, o.rf_wr_en})), 1);
            if (o.done && first_done < 0) first_done = k;
            if (k == poke_k) driveIn(r.dut, 1'b1, poke_ins);
            if (k == abort_k) begin
                rstn = 1'b0;
                #1;
                checkVec($sformatf("async reset d%0d k%0d", r.dut, k), getObs(r.dut), '0);
                @(negedge clk);
                rstn = 1'b1;
                return;
            end
            if (hold && k == r.lat) driveIn(r.dut, 1'b1, hold_ins);
        end
        checkInt($sformatf("latency d%0d op %h", r.dut, r.instr), first_done, r.lat);
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog expired checks=%0d", checks);
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        rstn = 1'b0;
        driveIn(0, 1'b0, 16'h0000);
        driveIn(1, 1'b0, 16'h0000);
        driveIn(2, 1'b0, 16'h0000);
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkVec("reset a", obs_a, '0);
        checkVec("reset b", obs_b, '0);
        checkVec("reset c", obs_c, '0);
        rstn = 1'b1;

        // ADD r3 = r1 + r2 with write-back: 33 cycles
        applyStimulus(0, mkR(4'h0, 3'd3, 3'd1, 3'd2));
        checkOutput(-1, 16'h0, 1'b0, 16'h0, -1);

        // SUBI r4 = r5 - 2: sign-extended immediate, inverted B, carry-in 1
        applyStimulus(0, mkI(4'h9, 3'd4, 3'd5, 6'b111110));
        checkOutput(-1, 16'h0, 1'b0, 16'h0, -1);

        // XOR to r0 suppresses write-back; WB_EN=0 instance skips it for r3 too
        applyStimulus(0, mkR(4'h6, 3'd0, 3'd2, 3'd7));
        checkOutput(-1, 16'h0, 1'b0, 16'h0, -1);
        applyStimulus(1, mkR(4'h6, 3'd3, 3'd2, 3'd7));
        checkOutput(-1, 16'h0, 1'b0, 16'h0, -1);
        applyStimulus(1, mkR(4'h1, 3'd5, 3'd6, 3'd1));
        checkOutput(-1, 16'h0, 1'b0, 16'h0, -1);

        // Undefined opcode goes straight to DONE with illegal
        applyStimulus(0, mkR(4'h7, 3'd2, 3'd3, 3'd4));
        checkOutput(-1, 16'h0, 1'b0, 16'h0, -1);

        // OR with a stray start mid-EXEC, start held through DONE, then back-to-back ANDI
        applyStimulus(0, mkR(4'h4, 3'd2, 3'd6, 3'd7));
        checkOutput(20, mkR(4'h5, 3'd7, 3'd1, 3'd1), 1'b1, mkI(4'hE, 3'd1, 3'd1, 6'b000001), -1);
        applyStimulus(0, mkI(4'hD, 3'd5, 3'd3, 6'b011010));
        checkOutput(-1, 16'h0, 1'b0, 16'h0, -1);

        // 16-bit instance: reset during LOAD_B, then full ADDI runs with sign-extended imm
        applyStimulus(2, mkR(4'h0, 3'd1, 3'd2, 3'd3));
        checkOutput(-1, 16'h0, 1'b0, 16'h0, 20);
        applyStimulus(2, mkI(4'h8, 3'd1, 3'd2, 6'b100101));
        checkOutput(-1, 16'h0, 1'b0, 16'h0, -1);
        applyStimulus(2, mkI(4'hC, 3'd6, 3'd4, 6'b010110));
        checkOutput(-1, 16'h0, 1'b0, 16'h0, -1);
        applyStimulus(2, mkI(4'hA, 3'd6, 3'd4, 6'b010110));
        checkOutput(-1, 16'h0, 1'b0, 16'h0, -1);

        @(negedge clk);
        checkVec("final idle a", obs_a, '0);
        checkVec("final idle b", obs_b, '0);
        checkVec("final idle c", obs_c, '0);
        checkInt("scoreboard drained", sb.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
